// File: rtl/seg_scan_decoder_if.sv
// Display snoop bundle: select/segment pins in, decoded frame results out.
interface seg_scan_decoder_if;
    logic [4:0]  seg_sel_in;
    logic [7:0]  seg_led_in;
    logic [16:0] num_out;
    logic [19:0] digits_out;
    logic        num_valid;
    logic        frame_err;

    modport master (
        output seg_sel_in,
        output seg_led_in,
        input  num_out,
        input  digits_out,
        input  num_valid,
        input  frame_err
    );

    modport slave (
        input  seg_sel_in,
        input  seg_led_in,
        output num_out,
        output digits_out,
        output num_valid,
        output frame_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Snoops a 5-digit multiplexed seven-segment scan and rebuilds the number.
module seg_scan_decoder #(
    parameter int SETTLE    = 4,
    parameter int DWELL_MAX = 100_000
) (
    input logic               sys_clk,
    input logic               sys_rst,
    seg_scan_decoder_if.slave io_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_CONVERT,
        S_DONE
    } state_t;

    localparam logic [4:0]  LP_SEL_D5  = 5'b11110;
    localparam logic [15:0] LP_SET_END = 16'(SETTLE - 1);
    localparam logic [16:0] LP_DWELL   = 17'(DWELL_MAX);
    localparam logic [16:0] LP_SAT     = 17'h1FFFF;

    state_t r_state;
    state_t w_next;

    logic [4:0]       r_sel_s1;
    logic [4:0]       r_sel_s2;
    logic [4:0]       r_sel_prev;
    logic [7:0]       r_led_s1;
    logic [7:0]       r_led_s2;
    logic [2:0]       r_pos;
    logic [4:0][3:0]  r_dig;
    logic [15:0]      r_settle;
    logic [16:0]      r_dwell;
    logic [16:0]      r_acc;
    logic [2:0]       r_cidx;
    logic [16:0]      r_num;
    logic [19:0]      r_digits;
    logic             r_valid;
    logic             r_err;

    logic             w_chg;
    logic [4:0]       w_succ;
    logic [4:0]       w_dec;
    logic             w_start;
    logic             w_adv;
    logic             w_store;
    logic             w_err;
    logic             w_cvt;
    logic             w_done;

    // Returns {valid, bcd}; dp (bit 7) is don't-care.
    function automatic logic [4:0] seg2bcd(input logic [7:0] s);
        logic [4:0] r;
        r = 5'b0;
        casez (s)
            8'b?011_1111: r = {1'b1, 4'd0};
            8'b?000_0110: r = {1'b1, 4'd1};
            8'b?101_1011: r = {1'b1, 4'd2};
            8'b?100_1111: r = {1'b1, 4'd3};
            8'b?110_0110: r = {1'b1, 4'd4};
            8'b?110_1101: r = {1'b1, 4'd5};
            8'b?111_1101: r = {1'b1, 4'd6};
            8'b?000_0111: r = {1'b1, 4'd7};
            8'b?111_1111: r = {1'b1, 4'd8};
            8'b?110_1111: r = {1'b1, 4'd9};
            default:      r = 5'b0;
        endcase
        return r;
    endfunction

    assign w_chg  = (r_sel_s2 != r_sel_prev);
    assign w_succ = {r_sel_prev[3:0], r_sel_prev[4]};
    assign w_dec  = seg2bcd(r_led_s2);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_store = 1'b0;
        w_err   = 1'b0;
        w_cvt   = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_chg && r_sel_s2 == LP_SEL_D5) begin
                    w_next  = S_SETTLE;
                    w_start = 1'b1;
                end
            end
            S_SETTLE, S_DWELL: begin
                if (w_chg) begin
                    if (r_sel_s2 == w_succ && r_pos != 3'd4) begin
                        w_next = S_SETTLE;
                        w_adv  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                        if (r_sel_s2 == LP_SEL_D5) begin
                            w_next  = S_SETTLE;
                            w_start = 1'b1;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end else if (r_state == S_SETTLE) begin
                    if (r_settle == LP_SET_END) begin
                        if (w_dec[4]) begin
                            w_store = 1'b1;
                            w_next  = (r_pos == 3'd4) ? S_CONVERT : S_DWELL;
                        end else begin
                            w_err  = 1'b1;
                            w_next = S_IDLE;
                        end
                    end
                end else if (r_dwell >= LP_DWELL) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_CONVERT: begin
                w_cvt = 1'b1;
                if (r_cidx == 3'd4) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sel_s1   <= 5'h1F;
            r_sel_s2   <= 5'h1F;
            r_sel_prev <= 5'h1F;
            r_led_s1   <= 8'h00;
            r_led_s2   <= 8'h00;
            r_pos      <= 3'd0;
            r_dig      <= '0;
            r_settle   <= 16'd0;
            r_dwell    <= 17'd0;
            r_acc      <= 17'd0;
            r_cidx     <= 3'd0;
            r_num      <= 17'd0;
            r_digits   <= 20'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sel_s1   <= io_bus.seg_sel_in;
            r_sel_s2   <= r_sel_s1;
            r_sel_prev <= r_sel_s2;
            r_led_s1   <= io_bus.seg_led_in;
            r_led_s2   <= r_led_s1;

            if (w_chg)                r_dwell <= 17'd0;
            else if (r_dwell != LP_SAT) r_dwell <= r_dwell + 17'd1;

            if (w_start) begin
                r_pos    <= 3'd0;
                r_settle <= 16'd0;
            end else if (w_adv) begin
                r_pos    <= r_pos + 3'd1;
                r_settle <= 16'd0;
            end else if (r_state == S_SETTLE) begin
                r_settle <= r_settle + 16'd1;
            end

            if (w_store) r_dig[r_pos] <= w_dec[3:0];

            // Units digit stored: prime the MSD-first accumulate.
            if (w_store && r_pos == 3'd4) begin
                r_acc  <= 17'd0;
                r_cidx <= 3'd0;
            end else if (w_cvt) begin
                r_acc  <= (r_acc << 3) + (r_acc << 1) + {13'd0, r_dig[r_cidx]};
                r_cidx <= r_cidx + 3'd1;
            end

            r_valid <= w_done;
            r_err   <= w_err;
            if (w_done) begin
                r_num    <= r_acc;
                r_digits <= {r_dig[0], r_dig[1], r_dig[2], r_dig[3], r_dig[4]};
            end
        end
    end

    assign io_bus.num_out    = r_num;
    assign io_bus.digits_out = r_digits;
    assign io_bus.num_valid  = r_valid;
    assign io_bus.frame_err  = r_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench: models the scanning display driver and checks decoded frames.
module tb_seg_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_val  = 0;
    int   n_err  = 0;
    int   n_both = 0;
    int   v0;
    int   e0;

    seg_scan_decoder_if io ();

    seg_scan_decoder #(
        .SETTLE    (4),
        .DWELL_MAX (300)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .io_bus  (io)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (io.num_valid) n_val++;
        if (io.frame_err) n_err++;
        if (io.num_valid && io.frame_err) n_both++;
    end

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            default: return 8'h6F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] s, input logic [7:0] l, input int n);
        io.seg_sel_in = s;
        io.seg_led_in = l;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One scan frame, d5 first; optional bad byte and stretched dwell.
    task automatic frame(input logic [19:0] bcd, input logic [7:0] dp,
                         input int bad_pos, input logic [7:0] bad_byte,
                         input int hold_pos, input int hold_cyc);
        logic [4:0] s;
        logic [7:0] l;
        for (int i = 0; i < 5; i++) begin
            s = ~(5'b00001 << i);
            l = seg(bcd[19-4*i -: 4]) | dp;
            if (i == bad_pos) l = bad_byte;
            drive(s, l, (i == hold_pos) ? hold_cyc : 20);
        end
    endtask

    initial begin
        io.seg_sel_in = 5'h1F;
        io.seg_led_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_num", 32'(io.num_out), 32'd0);
        chk("rst_digits", 32'(io.digits_out), 32'd0);
        chk("rst_valid", 32'(io.num_valid), 32'd0);
        chk("rst_err", 32'(io.frame_err), 32'd0);
        rst = 1'b0;
        drive(5'h1F, 8'h00, 5);

        v0 = n_val; e0 = n_err;
        frame(20'h12345, 8'h00, -1, 8'h00, -1, 0);
        chk("f12345_a_valid", 32'(n_val - v0), 32'd1);
        frame(20'h12345, 8'h00, -1, 8'h00, -1, 0);
        drive(5'h1F, 8'h00, 10);
        chk("f12345_valid", 32'(n_val - v0), 32'd2);
        chk("f12345_err", 32'(n_err - e0), 32'd0);
        chk("f12345_num", 32'(io.num_out), 32'd12345);
        chk("f12345_bcd", 32'(io.digits_out), 32'h12345);

        v0 = n_val; e0 = n_err;
        for (int k = 0; k < 3; k++) frame(20'h65535, 8'h80, -1, 8'h00, -1, 0);
        drive(5'h1F, 8'h00, 10);
        chk("dp_valid", 32'(n_val - v0), 32'd3);
        chk("dp_err", 32'(n_err - e0), 32'd0);
        chk("dp_num", 32'(io.num_out), 32'd65535);
        chk("dp_bcd", 32'(io.digits_out), 32'h65535);

        v0 = n_val; e0 = n_err;
        frame(20'h11111, 8'h00, 2, 8'h49, -1, 0);
        chk("badseg_err", 32'(n_err - e0), 32'd1);
        chk("badseg_valid", 32'(n_val - v0), 32'd0);
        chk("badseg_hold", 32'(io.num_out), 32'd65535);
        v0 = n_val; e0 = n_err;
        frame(20'h00042, 8'h00, -1, 8'h00, -1, 0);
        drive(5'h1F, 8'h00, 10);
        chk("f42_valid", 32'(n_val - v0), 32'd1);
        chk("f42_err", 32'(n_err - e0), 32'd0);
        chk("f42_num", 32'(io.num_out), 32'd42);
        chk("f42_bcd", 32'(io.digits_out), 32'h00042);

        v0 = n_val; e0 = n_err;
        drive(5'b11110, seg(4'd1), 20);
        drive(5'b11101, seg(4'd2), 20);
        drive(5'b10111, seg(4'd3), 20);
        drive(5'h1F, 8'h00, 10);
        chk("skip_err", 32'(n_err - e0), 32'd1);
        chk("skip_valid", 32'(n_val - v0), 32'd0);
        v0 = n_val; e0 = n_err;
        frame(20'h98765, 8'h00, -1, 8'h00, -1, 0);
        drive(5'h1F, 8'h00, 10);
        chk("f98765_valid", 32'(n_val - v0), 32'd1);
        chk("f98765_num", 32'(io.num_out), 32'd98765);
        chk("f98765_err", 32'(n_err - e0), 32'd0);

        v0 = n_val; e0 = n_err;
        frame(20'h20718, 8'h00, -1, 8'h00, 2, 280);
        drive(5'h1F, 8'h00, 10);
        chk("longdwell_valid", 32'(n_val - v0), 32'd1);
        chk("longdwell_err", 32'(n_err - e0), 32'd0);
        chk("longdwell_num", 32'(io.num_out), 32'd20718);

        v0 = n_val; e0 = n_err;
        drive(5'b11110, seg(4'd5), 20);
        drive(5'b11101, seg(4'd5), 20);
        drive(5'b11011, seg(4'd5), 310);
        drive(5'h1F, 8'h00, 10);
        chk("timeout_err", 32'(n_err - e0), 32'd1);
        chk("timeout_valid", 32'(n_val - v0), 32'd0);
        chk("timeout_hold", 32'(io.num_out), 32'd20718);

        v0 = n_val;
        drive(5'b11110, seg(4'd7), 20);
        drive(5'b11101, seg(4'd7), 20);
        drive(5'b11011, seg(4'd7), 20);
        drive(5'b10111, seg(4'd7), 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_num", 32'(io.num_out), 32'd0);
        chk("midrst_bcd", 32'(io.digits_out), 32'd0);
        drive(5'b10111, seg(4'd7), 9);
        drive(5'b01111, seg(4'd7), 20);
        drive(5'h1F, 8'h00, 10);
        chk("midrst_novalid", 32'(n_val - v0), 32'd0);
        frame(20'h31416, 8'h00, -1, 8'h00, -1, 0);
        drive(5'h1F, 8'h00, 10);
        chk("midrst_valid", 32'(n_val - v0), 32'd1);
        chk("midrst_after", 32'(io.num_out), 32'd31416);
        chk("never_both", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed 5-digit seven-segment display driver. Snoops the digit-select (`seg_sel`) and segment (`seg_led`) lines and decodes each segment pattern back to a BCD digit. It reassembles one complete scan frame (ten-thousands through units) and converts it to binary, presenting the value with a one-cycle valid pulse. It is used for board-level loopback checking of the display path and for reading a display-format number from another board.

## Interface
- `SETTLE`, 4: cycles after a detected `seg_sel` change before `seg_led` is sampled (min 2).
- `DWELL_MAX`, 100_000: maximum cycles `seg_sel` may stay constant while a frame is in progress.
- `sys_clk` input 1: system clock.
- `sys_rst` input 1: synchronous, active-high reset.
- `seg_sel_in` input 5: digit select, active-low one-hot.
- `seg_led_in` input 8: segments, active-high, bit0=a … bit6=g, bit7=dp.
- `num_out` output 17: decoded binary value, 0..99999.
- `digits_out` output 20: BCD {d5,d4,d3,d2,d1}, d5 = ten-thousands.
- `num_valid` output 1: one-cycle pulse when `num_out`/`digits_out` update.
- `frame_err` output 1: one-cycle pulse when a frame is abandoned.

## Operation
- **Input synchronisation**
  - Both inputs pass through a 2-flop synchroniser; all logic uses the synchronised copies.
  - A change is detected when synced `sel` differs from its previous-cycle value.
- **Position map**
  - 11110 = d5, 11101 = d4, 11011 = d3, 10111 = d2, 01111 = d1.
  - The expected successor is the rotate-left of the current select: 11110→11101→11011→10111→01111.
- **Segment decode** (bit7 masked, `seg_led[6:0]`)
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9.
  - Any other pattern, including 0x00, is invalid.
- **State machine**
  - IDLE: wait for a change to 11110, then go to SETTLE_WAIT with position = d5.
  - SETTLE_WAIT: count `SETTLE` cycles, then sample `seg_led` and decode.
    - Valid pattern: store the digit. Units position → CONVERT; otherwise → DWELL.
    - Invalid pattern: `frame_err`, go to IDLE.
  - DWELL: wait for a change.
    - Change to the expected successor: SETTLE_WAIT with the next position.
    - Change to any other value: `frame_err`. If the new select is 11110, restart at d5 in SETTLE_WAIT; otherwise go to IDLE.
    - Dwell counter reaches `DWELL_MAX`: `frame_err`, go to IDLE.
  - CONVERT: 5 cycles, acc = acc*10 + digit, from d5 down to d1. `*10` is implemented as (acc<<3)+(acc<<1); acc is 17 bits wide.
  - DONE: 1 cycle. Load `num_out` and `digits_out`, pulse `num_valid`, go to IDLE.
- A change on `seg_sel` during CONVERT/DONE is ignored. IDLE re-arms on the next change to 11110, so consecutive frames from a free-running driver are each decoded.
- A change during SETTLE_WAIT restarts the settle count for the new select value, with the same successor/error rules as DWELL.
- Outputs hold their last valid frame; `frame_err` never alters `num_out` or `digits_out`.

## Timing
- Reset values: `num_out`=0, `digits_out`=0, `num_valid`=0, `frame_err`=0, state=IDLE, all counters 0.
- `sys_rst` asserted at any point, including mid-frame, returns everything to reset values on the next edge. The partial frame is discarded.
- Select change detected 2 cycles after the pin changes (synchroniser latency).
- Sample edge = detect edge + `SETTLE`.
- `num_valid` is high on edge units-sample + 6, and `num_out` is valid on that same cycle.
- `frame_err` asserts on the edge the fault is detected. `num_valid` and `frame_err` are never high together.
- Dwell counter: 17 bits, cleared on every change, saturating.

## Test plan
- Driver model with num=12345, scan period 20 cycles, `SETTLE`=4 → `num_valid` once per 100-cycle frame; `num_out`=12345; `digits_out`=0x12345.
- num=65535 over 3 frames, dp bit forced to 1 → three `num_valid` pulses, each with `num_out`=65535 (dp ignored); no `frame_err`.
- Frame 1: d3 segment byte = 0x49 → one `frame_err` at the d3 sample, no `num_valid` that frame, `num_out` keeps its old value. Frame 2 (num=00042) decodes to `num_out`=42.
- Sequence 11110→11101→10111 → `frame_err` on the 10111 detection, back to IDLE; next clean frame decodes correctly.
- Select held at 11011 for `DWELL_MAX`+10 cycles → exactly one `frame_err`, state IDLE, no `num_valid`.
- `sys_rst` pulsed during the d2 dwell → outputs zero next cycle; `num_valid` only after a complete new frame starting at 11110.
